// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the immediate-generator pipeline:
//   - imm_type_e : immediate type codes (110 and 111 are illegal)
//   - ZIMM_W     : width of the CSR zimm field (instr[19:15])
//   - xlen_legal : elaboration-time check of the XLEN parameter
// -----------------------------------------------------------------------------
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100,
        IMM_Z = 3'b101
    } imm_type_e;

    localparam int ZIMM_W = 5;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe_if
// Request/response bundle of the immediate-generator pipeline.
//   in_valid/in_ready   : request handshake (producer -> pipe)
//   in_instr[24:0]      : instruction bits 31..7
//   in_type[2:0]        : immediate type code
//   in_tag[TAG_W-1:0]   : sideband tag, returned unchanged
//   out_valid/out_ready : response handshake (pipe -> consumer)
//   out_imm[XLEN-1:0]   : decoded immediate
//   out_tag, out_err    : tag and illegal-type flag of the head entry
// Modports: master = producer/consumer side, slave = the pipeline.
// -----------------------------------------------------------------------------
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      in_instr;
    logic [2:0]       in_type;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_instr, in_type, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_instr, in_type, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );
endinterface

// File: rtl/imm_decode_core.sv
// -----------------------------------------------------------------------------
// imm_decode_core
// Purely combinational RISC-V immediate extraction.
//   instr_i[24:0] : instruction bits 31..7
//   type_i[2:0]   : immediate type code (imm_pkg::imm_type_e)
//   imm_o         : immediate, extended to XLEN (0 for an illegal type)
//   err_o         : high for the illegal codes 110/111
// -----------------------------------------------------------------------------
module imm_decode_core
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]     instr_i,
    input  logic [2:0]      type_i,
    output logic [XLEN-1:0] imm_o,
    output logic            err_o
);

    // Re-index so bit numbers match the architectural instruction layout.
    logic [31:7]        ins;
    logic signed [31:0] imm32;

    assign ins = instr_i;

    always_comb begin
        imm32 = '0;
        err_o = 1'b0;
        case (type_i)
            IMM_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm32 = {ins[31:12], 12'b0};
            IMM_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            IMM_Z:   imm32 = {{(32-ZIMM_W){1'b0}}, ins[19:15]};
            default: begin
                imm32 = '0;
                err_o = 1'b1;
            end
        endcase
    end

    // Signed size cast sign-extends; the zimm value is already non-negative.
    assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Decodes an immediate when a request is accepted and buffers the result in a
// DEPTH-entry FIFO; the head entry is presented one cycle after acceptance.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   flush : synchronous discard of all entries (wins over push/pop)
//   bus   : imm_gen_pipe_if.slave request/response bundle
// Optional feature macro: IMM_ILLEGAL_TRAP_EN -- store a per-entry illegal-type
// flag and present it on out_err; otherwise out_err is tied low.
// -----------------------------------------------------------------------------
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    imm_gen_pipe_if.slave   bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("imm_gen_pipe: DEPTH must be a power of two >= 2");
    end

    logic [XLEN-1:0]  mem_imm_q [DEPTH];
    logic [TAG_W-1:0] mem_tag_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full, empty, push, pop;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_err;

    imm_decode_core #(.XLEN(XLEN)) u_dec (
        .instr_i (bus.in_instr),
        .type_i  (bus.in_type),
        .imm_o   (dec_imm),
        .err_o   (dec_err)
    );

    // Handshake depends only on registered occupancy, never on out_ready.
    assign full         = (cnt_q == CW'(DEPTH));
    assign empty        = (cnt_q == '0);
    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full && !flush;
    assign pop          = !empty && bus.out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is data only; validity comes from the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_imm_q[wr_ptr_q] <= dec_imm;
            mem_tag_q[wr_ptr_q] <= bus.in_tag;
        end
    end

    // Outputs are masked to zero when empty so reset clears them immediately.
    assign bus.out_valid = !empty;
    assign bus.out_imm   = empty ? '0 : mem_imm_q[rd_ptr_q];
    assign bus.out_tag   = empty ? '0 : mem_tag_q[rd_ptr_q];

`ifdef IMM_ILLEGAL_TRAP_EN
    logic mem_err_q [DEPTH];

    always_ff @(posedge clk) begin
        if (push) mem_err_q[wr_ptr_q] <= dec_err;
    end

    assign bus.out_err = empty ? 1'b0 : mem_err_q[rd_ptr_q];
`else
    logic unused_dec_err;
    assign unused_dec_err = dec_err;
    assign bus.out_err    = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Directed bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance (both
// DEPTH=2) are driven with identical stimulus.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(5)) dut32 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (b32.slave)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(5)) dut64 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (b64.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

`ifdef IMM_ILLEGAL_TRAP_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    localparam int NV = 13;
    localparam logic [31:0] V_INS [NV] = '{
        32'hFFF00093, 32'h7FF00093, 32'h00112423, 32'hFE112E23, 32'hFE000EE3,
        32'h00000463, 32'h12345037, 32'h80000037, 32'hFFDFF06F, 32'h0100006F,
        32'h800F8073, 32'hFFFFFFFF, 32'hFFFFFFFF };
    localparam logic [2:0] V_TYP [NV] = '{
        3'b000, 3'b000, 3'b001, 3'b001, 3'b010,
        3'b010, 3'b011, 3'b011, 3'b100, 3'b100,
        3'b101, 3'b110, 3'b111 };
    localparam logic [63:0] V_EXP [NV] = '{
        64'hFFFFFFFF_FFFFFFFF, 64'h00000000_000007FF, 64'h00000000_00000008,
        64'hFFFFFFFF_FFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 64'h00000000_00000008,
        64'h00000000_12345000, 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_FFFFFFFC,
        64'h00000000_00000010, 64'h00000000_0000001F, 64'h00000000_00000000,
        64'h00000000_00000000 };
    localparam logic V_ILL [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    task automatic drive_in(input logic v, input logic [31:0] instr,
                            input logic [2:0] t, input logic [4:0] tag);
        b32.in_valid = v; b32.in_instr = instr[31:7]; b32.in_type = t; b32.in_tag = tag;
        b64.in_valid = v; b64.in_instr = instr[31:7]; b64.in_type = t; b64.in_tag = tag;
    endtask

    task automatic set_ready(input logic r);
        b32.out_ready = r;
        b64.out_ready = r;
    endtask

    task automatic push_tag(input logic [4:0] tag);
        @(negedge clk);
        drive_in(1'b1, 32'h00000013, 3'b000, tag);
        @(posedge clk);
        #1;
        drive_in(1'b0, 32'h0, 3'b000, 5'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        drive_in(1'b0, 32'h0, 3'b000, 5'd0);
        set_ready(1'b0);
        #12;
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", b32.out_valid); end
        n_cmp++; if (b32.out_imm !== 32'h0) begin n_bad++; $display("FAIL reset_out_imm32 got %h want 0", b32.out_imm); end
        n_cmp++; if (b64.out_imm !== 64'h0) begin n_bad++; $display("FAIL reset_out_imm64 got %h want 0", b64.out_imm); end
        n_cmp++; if (b32.out_tag !== 5'h0) begin n_bad++; $display("FAIL reset_out_tag got %h want 0", b32.out_tag); end
        n_cmp++; if (b32.out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err got %b want 0", b32.out_err); end
        n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", b32.in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_decode();
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            set_ready(1'b0);
            drive_in(1'b1, V_INS[i], V_TYP[i], 5'(i + 3));
            @(posedge clk);
            #1;
            drive_in(1'b0, 32'h0, 3'b000, 5'd0);
            n_cmp++; if (b32.out_valid !== 1'b1) begin n_bad++; $display("FAIL decode[%0d] out_valid got %b want 1", i, b32.out_valid); end
            n_cmp++; if (b32.out_imm !== V_EXP[i][31:0]) begin n_bad++; $display("FAIL decode[%0d] imm32 got %h want %h", i, b32.out_imm, V_EXP[i][31:0]); end
            n_cmp++; if (b64.out_imm !== V_EXP[i]) begin n_bad++; $display("FAIL decode[%0d] imm64 got %h want %h", i, b64.out_imm, V_EXP[i]); end
            n_cmp++; if (b32.out_tag !== 5'(i + 3)) begin n_bad++; $display("FAIL decode[%0d] tag got %h want %h", i, b32.out_tag, 5'(i + 3)); end
            n_cmp++; if (b32.out_err !== (V_ILL[i] & EXP_ERR)) begin n_bad++; $display("FAIL decode[%0d] err got %b want %b", i, b32.out_err, V_ILL[i] & EXP_ERR); end
            @(negedge clk);
            set_ready(1'b1);
            @(posedge clk);
            #1;
            set_ready(1'b0);
            n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL decode[%0d] drain out_valid got %b want 0", i, b32.out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        set_ready(1'b0);
        @(negedge clk);
        drive_in(1'b1, 32'hFFF00093, 3'b000, 5'd1);
        @(posedge clk);
        #1;
        n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b in_ready_after1 got %b want 1", b32.in_ready); end
        @(negedge clk);
        drive_in(1'b1, 32'h12345037, 3'b011, 5'd2);
        @(posedge clk);
        #1;
        n_cmp++; if (b32.in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b in_ready_after2 got %b want 0", b32.in_ready); end
        @(negedge clk);
        drive_in(1'b1, 32'h00112423, 3'b001, 5'd3);
        @(posedge clk);
        #1;
        drive_in(1'b0, 32'h0, 3'b000, 5'd0);
        n_cmp++; if (b32.out_tag !== 5'd1) begin n_bad++; $display("FAIL b2b stall_tag got %h want 1", b32.out_tag); end
        @(posedge clk);
        #1;
        n_cmp++; if (b32.out_imm !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL b2b stall_imm got %h want ffffffff", b32.out_imm); end
        n_cmp++; if (b32.out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b stall_valid got %b want 1", b32.out_valid); end
        @(negedge clk);
        set_ready(1'b1);
        @(posedge clk);
        #1;
        n_cmp++; if (b32.out_tag !== 5'd2) begin n_bad++; $display("FAIL b2b second_tag got %h want 2", b32.out_tag); end
        n_cmp++; if (b32.out_imm !== 32'h12345000) begin n_bad++; $display("FAIL b2b second_imm got %h want 12345000", b32.out_imm); end
        @(posedge clk);
        #1;
        set_ready(1'b0);
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b tag3_dropped out_valid got %b want 0", b32.out_valid); end
    endtask

    task automatic test_full_pop_no_push();
        set_ready(1'b0);
        push_tag(5'd1);
        push_tag(5'd2);
        @(negedge clk);
        drive_in(1'b1, 32'h00000013, 3'b000, 5'd9);
        set_ready(1'b1);
        @(posedge clk);
        #1;
        drive_in(1'b0, 32'h0, 3'b000, 5'd0);
        n_cmp++; if (b32.out_tag !== 5'd2) begin n_bad++; $display("FAIL fullpop head_tag got %h want 2", b32.out_tag); end
        n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL fullpop in_ready got %b want 1", b32.in_ready); end
        @(posedge clk);
        #1;
        set_ready(1'b0);
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL fullpop push_blocked out_valid got %b want 0", b32.out_valid); end
    endtask

    task automatic test_push_pop_same();
        set_ready(1'b0);
        push_tag(5'd4);
        @(negedge clk);
        drive_in(1'b1, 32'h00000013, 3'b000, 5'd5);
        set_ready(1'b1);
        @(posedge clk);
        #1;
        drive_in(1'b0, 32'h0, 3'b000, 5'd0);
        set_ready(1'b0);
        n_cmp++; if (b32.out_valid !== 1'b1) begin n_bad++; $display("FAIL pushpop out_valid got %b want 1", b32.out_valid); end
        n_cmp++; if (b32.out_tag !== 5'd5) begin n_bad++; $display("FAIL pushpop out_tag got %h want 5", b32.out_tag); end
        n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL pushpop in_ready got %b want 1", b32.in_ready); end
        @(negedge clk);
        set_ready(1'b1);
        @(posedge clk);
        #1;
        set_ready(1'b0);
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL pushpop drained out_valid got %b want 0", b32.out_valid); end
    endtask

    task automatic test_flush();
        set_ready(1'b0);
        push_tag(5'd1);
        push_tag(5'd2);
        @(negedge clk);
        flush = 1'b1;
        drive_in(1'b1, 32'h00000013, 3'b000, 5'd7);
        @(posedge clk);
        #1;
        flush = 1'b0;
        drive_in(1'b0, 32'h0, 3'b000, 5'd0);
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush out_valid got %b want 0", b32.out_valid); end
        n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush in_ready got %b want 1", b32.in_ready); end
        @(posedge clk);
        #1;
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush dropped_req out_valid got %b want 0", b32.out_valid); end
        push_tag(5'd3);
        n_cmp++; if (b32.out_tag !== 5'd3) begin n_bad++; $display("FAIL flush post_tag got %h want 3", b32.out_tag); end
        @(negedge clk);
        set_ready(1'b1);
        @(posedge clk);
        #1;
        set_ready(1'b0);
    endtask

    task automatic test_reset_midstream();
        set_ready(1'b0);
        push_tag(5'd1);
        push_tag(5'd2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst out_valid got %b want 0", b32.out_valid); end
        n_cmp++; if (b32.out_tag !== 5'd0) begin n_bad++; $display("FAIL midrst out_tag got %h want 0", b32.out_tag); end
        n_cmp++; if (b64.out_imm !== 64'h0) begin n_bad++; $display("FAIL midrst out_imm64 got %h want 0", b64.out_imm); end
        n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst in_ready got %b want 1", b32.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst stale out_valid got %b want 0", b32.out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_full_pop_no_push();
        test_push_pop_same();
        test_flush();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate width; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries; power of two, at least 2.
REQ-003 SHALL have parameter TAG_W, default 5, width of the sideband tag carried with each immediate.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 flush  in  1  synchronous discard of all buffered entries.
REQ-008 in_valid  in  1  request valid.
REQ-009 in_ready  out  1  buffer can accept.
REQ-010 in_instr  in  25  instruction bits 31 down to 7.
REQ-011 in_type  in  3  immediate type code.
REQ-012 in_tag  in  TAG_W  sideband tag, returned unchanged.
REQ-013 out_valid  out  1  head entry valid.
REQ-014 out_ready  in  1  consumer accepts.
REQ-015 out_imm  out  XLEN  decoded immediate.
REQ-016 out_tag  out  TAG_W  tag of head entry.
REQ-017 out_err  out  1  head entry had an illegal type (macro-dependent).

Function
REQ-018 Type codes SHALL be: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR zimm); 110 and 111 are illegal.
REQ-019 The I, S, B and J immediates SHALL be sign-extended from bit 31 to XLEN.
REQ-020 The B and J immediates SHALL have bit 0 forced to 0.
REQ-021 The U immediate SHALL be {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
REQ-022 The Z immediate SHALL be instr[19:15] zero-extended to XLEN.
REQ-023 An illegal type SHALL produce an immediate of 0.
REQ-024 A request SHALL be accepted on a cycle with in_valid and in_ready both high.
REQ-025 Decoding SHALL happen at acceptance, and the result SHALL be stored in a DEPTH-entry FIFO.
REQ-026 Latency SHALL be 1 cycle: an entry accepted at cycle N into an empty FIFO shows out_valid=1 at cycle N+1.
REQ-027 There SHALL be no combinational path from in_valid or in_type to out_*.
REQ-028 in_ready SHALL equal !full, registered-derived, with no combinational dependence on out_ready.
REQ-029 When full, a simultaneous pop SHALL NOT admit a push in the same cycle.
REQ-030 An entry SHALL pop on a cycle with out_valid and out_ready both high.
REQ-031 A push and a pop in the same cycle (not full) SHALL leave the occupancy unchanged.
REQ-032 Pointers SHALL wrap modulo DEPTH, and occupancy SHALL be tracked with an extra count bit so that full and empty are unambiguous.
REQ-033 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-034 flush SHALL empty the FIFO at the next edge and take priority over a same-cycle push or pop.
REQ-035 A request presented during flush SHALL be dropped.

Reset
REQ-036 On rst high: out_valid=0, out_imm=0, out_tag=0, out_err=0, pointers and count=0, in_ready=1, taking effect immediately (asynchronous).
REQ-037 Reset mid-operation SHALL discard all entries, and no stale entry SHALL appear after release.

Configuration
REQ-038 With IMM_ILLEGAL_TRAP_EN defined, the FIFO SHALL store an err bit per entry, set for types 110/111, presented on out_err alongside the entry.
REQ-039 With IMM_ILLEGAL_TRAP_EN undefined, out_err SHALL be tied to 0 and no err storage SHALL exist.
REQ-040 The immediate value for an illegal type SHALL be 0 in both cases.

Structure
REQ-041 Package imm_pkg SHALL hold the type-code constants, the XLEN legality check, and the Z-type width constant.
REQ-042 Sub-module imm_decode_core SHALL hold the combinational extraction (instr, type -> imm, err) and be instantiated once at the FIFO write port.

Verification
REQ-043 XLEN=32, I type, instr 0xFFF00093 -> out_imm 0xFFFFFFFF, out_valid 1 cycle after accept; XLEN=64 -> 0xFFFFFFFFFFFFFFFF.
REQ-044 U type, 0x12345037 -> 0x12345000; XLEN=64 with 0x80000037 -> 0xFFFFFFFF80000000.
REQ-045 B type, 0xFE000EE3 -> 0xFFFFFFFC; J type, 0xFFDFF06F -> 0xFFFFFFFC; Z type, rs1 field 0x1F -> 0x0000001F.
REQ-046 DEPTH=2, out_ready=0, three back-to-back pushes tags 1,2,3 -> in_ready low after the second push and tag 3 not accepted; then out_ready=1 -> tags 1,2 in order, and the output holds stable while stalled.
REQ-047 Two entries buffered, flush asserted with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed request is never output; rst pulsed mid-stream -> out_valid drops immediately.
REQ-048 Type 111 with IMM_ILLEGAL_TRAP_EN -> out_imm 0, out_err 1; without the macro -> out_imm 0, out_err 0.
